// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter, 8E1 framing.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1) = 11 bits.
// Bit timing: a 16x oversample tick divided down from clk, so each bit lasts
// exactly OVERSAMPLE*CLKS_PER_TICK clk cycles. The edges line up with a
// receiver that samples at mid-bit (tick 8).
// Optional build macro UART_TX_HOLD_REG_EN adds a one-byte holding register
// in front of the shifter. With it, back-to-back frames have no idle gap.
module uart_tx #(
  parameter int CLKS_PER_TICK = 2,
  parameter int OVERSAMPLE    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       UARTn_CTS,
  output logic       UARTn_TXD,
  output logic       tx_busy
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
  localparam logic [3:0]    TICK_LAST  = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Registered state
  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [3:0]      r_tick;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_par;
  logic            r_txd;
  logic            r_cts_meta;
  logic            r_cts_s;

  // Next-state / control
  state_t          w_state_nxt;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      w_shift_nxt;
  logic            w_par_nxt;
  logic            w_txd_nxt;
  logic            w_cnt_clr;
  logic            w_bit_end;
  logic            w_accept;
  logic            w_start;
  logic [7:0]      w_frame_data;
  logic [2:0]      w_idx_inc;

  assign w_bit_end = (r_tick == TICK_LAST) && (r_presc == PRESC_LAST);
  assign w_accept  = tx_valid && tx_ready;
  assign w_idx_inc = r_bit_idx + 3'd1;

`ifdef UART_TX_HOLD_REG_EN
  logic       r_thr_full;
  logic [7:0] r_thr;
  logic       r_rst_done;

  // The holding register feeds the shifter at idle, or right at the stop bit end
  // so that the next start bit follows without a gap.
  assign w_start      = r_thr_full && r_cts_s &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_frame_data = r_thr;
  assign tx_ready     = r_rst_done && !r_thr_full;

  // Holding register: fill on accept, empty on load into the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thr      <= 8'h00;
      r_thr_full <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_thr      <= tx_data;
        r_thr_full <= 1'b1;
      end else if (w_start) begin
        r_thr_full <= 1'b0;
      end
    end
  end
`else
  // Without the holding register, a byte goes straight into the shifter.
  // It is accepted only from IDLE, so CTS is checked once, at frame start.
  assign w_start      = w_accept;
  assign w_frame_data = tx_data;
  assign tx_ready     = (r_state == S_IDLE) && r_cts_s;
`endif

  assign UARTn_TXD = r_txd;
  assign tx_busy   = (r_state != S_IDLE);

  // CTS comes from another clock domain; two flops before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cts_meta <= 1'b0;
      r_cts_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample old values on the
      // same edge; blocking here would collapse the synchronizer into one stage.
      r_cts_meta <= UARTn_CTS;
      r_cts_s    <= r_cts_meta;
    end
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_txd_nxt     = r_txd;
    w_cnt_clr     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (w_start) begin
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_shift_nxt = w_frame_data;
          w_par_nxt   = ^w_frame_data;
          w_cnt_clr   = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
          w_txd_nxt     = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_PARITY;
            w_txd_nxt   = r_par;
          end else begin
            w_bit_idx_nxt = w_idx_inc;
            w_txd_nxt     = r_shift[w_idx_inc];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (w_start) begin
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
            w_shift_nxt = w_frame_data;
            w_par_nxt   = ^w_frame_data;
            w_cnt_clr   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // State, datapath and line register. A reset drives the line idle-high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  // Baud timing: prescaler -> 16x tick counter. It restarts at frame start,
  // so every bit is exactly one full tick cycle long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_tick  <= 4'd0;
    end else if (w_cnt_clr || (r_state == S_IDLE)) begin
      r_presc <= '0;
      r_tick  <= 4'd0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_tick  <= (r_tick == TICK_LAST) ? 4'd0 : r_tick + 4'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Parameter sanity, checked in simulation; ignored by synthesis.
  a_param_range : assert property (@(posedge clk)
    (OVERSAMPLE == 16) && (CLKS_PER_TICK >= 1));

endmodule
